// File: rtl/bf16_div.sv
// ---------------------------------------------------------------------------
// bf16_div : iterative bfloat16 divider, result = a / b
//
// Restoring radix-2 significand division, one quotient bit per clock,
// followed by a single round-to-nearest-even step. Denormal inputs are
// flushed to zero and underflowing results are flushed to signed zero.
// One operation is in flight at a time behind a valid/ready handshake.
//
// Optional build macro: BF16_DIV_FLAGS_EN adds the flags output
//   flags = {invalid, div_by_zero, overflow, underflow}
//
// Ports
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   operands a, b presented
//   in_ready   out  divider idle and can accept
//   a          in   [15:0] dividend, bf16
//   b          in   [15:0] divisor, bf16
//   out_valid  out  result available
//   out_ready  in   consumer accepts result
//   result     out  [15:0] quotient, bf16
//   flags      out  [3:0] exception flags (BF16_DIV_FLAGS_EN only)
//
// state  | meaning
// IDLE   | in_ready=1, waiting for in_valid; latches operands
// DIVIDE | 11 cycles, one quotient bit per cycle
// ROUND  | normalise, round, range check (special results pass through)
// DONE   | out_valid=1, result held until out_ready
// ---------------------------------------------------------------------------
module bf16_div #(
    parameter int          EXP_BIAS = 127,
    parameter logic [15:0] QNAN     = 16'h7FC0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] result
`ifdef BF16_DIV_FLAGS_EN
    ,
    output logic [3:0]  flags
`endif
);

    typedef enum logic [1:0] {IDLE, DIVIDE, ROUND, DONE} state_t;

    state_t      r_state;
    logic        r_in_ready;
    logic        r_out_valid;
    logic [15:0] r_result;
    logic        r_sign;
    logic [8:0]  r_rem;
    logic [7:0]  r_div;
    logic [10:0] r_q;
    logic [9:0]  r_e;
    logic [3:0]  r_cnt;
    logic        r_special;
    logic [15:0] r_sp_result;

    // ---------------- operand classification ----------------
    logic w_a_zero, w_a_inf, w_a_nan;
    logic w_b_zero, w_b_inf, w_b_nan;
    logic w_sign;

    assign w_sign   = a[15] ^ b[15];
    assign w_a_zero = (a[14:7] == 8'h00);
    assign w_a_inf  = (a[14:7] == 8'hFF) && (a[6:0] == 7'h00);
    assign w_a_nan  = (a[14:7] == 8'hFF) && (a[6:0] != 7'h00);
    assign w_b_zero = (b[14:7] == 8'h00);
    assign w_b_inf  = (b[14:7] == 8'hFF) && (b[6:0] == 7'h00);
    assign w_b_nan  = (b[14:7] == 8'hFF) && (b[6:0] != 7'h00);

    logic        w_is_special;
    logic [15:0] w_sp_res;

    always_comb begin
        w_is_special = 1'b1;
        w_sp_res     = QNAN;
        if (w_a_nan || w_b_nan) begin
            w_sp_res = QNAN;
        end else if ((w_a_inf && w_b_inf) || (w_a_zero && w_b_zero)) begin
            w_sp_res = QNAN;
        end else if (w_a_inf || w_b_zero) begin
            w_sp_res = {w_sign, 8'hFF, 7'h00};
        end else if (w_a_zero || w_b_inf) begin
            w_sp_res = {w_sign, 15'h0000};
        end else begin
            w_is_special = 1'b0;
        end
    end

    logic [9:0] w_e_init;
    assign w_e_init = {2'b00, a[14:7]} - {2'b00, b[14:7]} + 10'(EXP_BIAS);

    // ---------------- divide step ----------------
    logic       w_rem_ge;
    logic [8:0] w_rem_nxt;

    assign w_rem_ge  = (r_rem >= {1'b0, r_div});
    assign w_rem_nxt = w_rem_ge ? (r_rem - {1'b0, r_div}) : r_rem;

    // ---------------- normalise and round ----------------
    // q lies in (0.5, 2); when q[10] is clear the leading one sits at q[9].
    logic [9:0]  w_qn;
    logic [9:0]  w_en;
    logic        w_sticky;
    logic        w_inc;
    logic [7:0]  w_fr8;
    logic [9:0]  w_ef;
    logic        w_ovf;
    logic        w_unf;
    logic [15:0] w_rnd_res;

    assign w_qn     = r_q[10] ? r_q[9:0] : {r_q[8:0], 1'b0};
    assign w_en     = r_q[10] ? r_e : (r_e - 10'd1);
    assign w_sticky = w_qn[0] | (r_rem != 9'd0);
    assign w_inc    = w_qn[2] & (w_qn[1] | w_sticky | w_qn[3]);
    // fraction plus increment; bit 7 is the carry into the hidden bit,
    // in which case the low 7 bits are already zero (1.0 renormalised).
    assign w_fr8    = {1'b0, w_qn[9:3]} + {7'd0, w_inc};
    assign w_ef     = w_en + {9'd0, w_fr8[7]};
    assign w_ovf    = ($signed(w_ef) >= 10'sd255);
    assign w_unf    = ($signed(w_ef) <= 10'sd0);

    always_comb begin
        w_rnd_res = {r_sign, w_ef[7:0], w_fr8[6:0]};
        if (w_ovf)
            w_rnd_res = {r_sign, 8'hFF, 7'h00};
        else if (w_unf)
            w_rnd_res = {r_sign, 15'h0000};
    end

`ifdef BF16_DIV_FLAGS_EN
    logic [3:0] r_flags;
    logic [3:0] r_sp_flags;
    logic [3:0] w_sp_flags;

    always_comb begin
        w_sp_flags = 4'b0000;
        if (w_a_nan || w_b_nan || (w_a_inf && w_b_inf) || (w_a_zero && w_b_zero))
            w_sp_flags = 4'b1000;
        else if (w_b_zero && !w_a_inf)
            w_sp_flags = 4'b0100;
    end

    assign flags = r_flags;
`endif

    // ---------------- control ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_result    <= 16'h0000;
            r_sign      <= 1'b0;
            r_rem       <= 9'd0;
            r_div       <= 8'd0;
            r_q         <= 11'd0;
            r_e         <= 10'd0;
            r_cnt       <= 4'd0;
            r_special   <= 1'b0;
            r_sp_result <= 16'h0000;
`ifdef BF16_DIV_FLAGS_EN
            r_flags     <= 4'b0000;
            r_sp_flags  <= 4'b0000;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_in_ready  <= 1'b0;
                        r_sign      <= w_sign;
                        r_special   <= w_is_special;
                        r_sp_result <= w_sp_res;
`ifdef BF16_DIV_FLAGS_EN
                        r_sp_flags  <= w_sp_flags;
`endif
                        r_rem       <= {2'b01, a[6:0]};
                        r_div       <= {1'b1, b[6:0]};
                        r_e         <= w_e_init;
                        r_q         <= 11'd0;
                        r_cnt       <= 4'd0;
                        // special results skip the iteration but still take
                        // one edge through ROUND before out_valid
                        r_state     <= w_is_special ? ROUND : DIVIDE;
                    end
                end
                DIVIDE: begin
                    r_q   <= {r_q[9:0], w_rem_ge};
                    r_rem <= w_rem_nxt << 1;
                    r_cnt <= r_cnt + 4'd1;
                    if (r_cnt == 4'd10)
                        r_state <= ROUND;
                end
                ROUND: begin
                    r_result    <= r_special ? r_sp_result : w_rnd_res;
                    r_out_valid <= 1'b1;
`ifdef BF16_DIV_FLAGS_EN
                    r_flags     <= r_special ? r_sp_flags
                                             : {2'b00, w_ovf, w_unf && !w_ovf};
`endif
                    r_state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
`ifdef BF16_DIV_FLAGS_EN
                        r_flags     <= 4'b0000;
`endif
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign result    = r_result;

endmodule

// File: tb/tb_bf16_div.sv
// ---------------------------------------------------------------------------
// tb_bf16_div : directed self-checking bench for bf16_div.
// Inputs are driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_bf16_div;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        in_valid  = 1'b0;
    logic        out_ready = 1'b0;
    logic [15:0] a         = 16'h0000;
    logic [15:0] b         = 16'h0000;
    logic        in_ready;
    logic        out_valid;
    logic [15:0] result;
`ifdef BF16_DIV_FLAGS_EN
    logic [3:0]  flags;
`endif

    int tests = 0;
    int fails = 0;

    bf16_div dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
`ifdef BF16_DIV_FLAGS_EN
        ,
        .flags     (flags)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one operation from a falling edge where the divider is idle,
    // optionally hold off out_ready for 'hold' cycles, then hand off.
    task automatic run_op(input string tag, input logic [15:0] ta, input logic [15:0] tb_op,
                          input logic [15:0] exp_res, input int exp_lat,
                          input logic [3:0] exp_flags, input int hold);
        int   n;
        logic busy_ok;
        logic stable;
        chk({tag, ":in_ready_idle"}, {31'd0, in_ready}, 32'd1);
        a        = ta;
        b        = tb_op;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        // junk operands kept valid while busy must be ignored
        a       = 16'h7FC1;
        b       = 16'h0000;
        n       = 0;
        busy_ok = 1'b1;
        while (!out_valid && n < 40) begin
            if (in_ready !== 1'b0) busy_ok = 1'b0;
            @(negedge clk);
            n++;
        end
        chk({tag, ":latency"}, n, exp_lat);
        chk({tag, ":busy_in_ready"}, {31'd0, busy_ok & ~in_ready}, 32'd1);
        chk({tag, ":result"}, {16'd0, result}, {16'd0, exp_res});
`ifdef BF16_DIV_FLAGS_EN
        chk({tag, ":flags"}, {28'd0, flags}, {28'd0, exp_flags});
`else
        if (exp_flags != exp_flags) $display("unreachable");
`endif
        stable = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (result !== exp_res || out_valid !== 1'b1 || in_ready !== 1'b0) stable = 1'b0;
        end
        if (hold > 0) chk({tag, ":hold_stable"}, {31'd0, stable}, 32'd1);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, ":handoff_valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, ":handoff_ready"}, {31'd0, in_ready}, 32'd1);
`ifdef BF16_DIV_FLAGS_EN
        chk({tag, ":flags_clr"}, {28'd0, flags}, 32'd0);
`endif
    endtask

    initial begin
        // reset state
        repeat (2) @(negedge clk);
        chk("rst:in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst:out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst:result", {16'd0, result}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // normal operands
        run_op("266/17",   16'h4385, 16'h4188, 16'h417A, 12, 4'b0000, 0);
        run_op("-17/17",   16'hC188, 16'h4188, 16'hBF80, 12, 4'b0000, 0);
        run_op("1/3",      16'h3F80, 16'h4040, 16'h3EAB, 12, 4'b0000, 0);
        run_op("ovf",      16'h7F00, 16'h3E80, 16'h7F80, 12, 4'b0010, 0);
        run_op("unf",      16'h0080, 16'h4000, 16'h0000, 12, 4'b0001, 0);

        // special cases
        run_op("1/0",      16'h3F80, 16'h0000, 16'h7F80, 1, 4'b0100, 0);
        run_op("0/0",      16'h0000, 16'h0000, 16'h7FC0, 1, 4'b1000, 0);
        run_op("nan/1",    16'h7FC1, 16'h3F80, 16'h7FC0, 1, 4'b1000, 0);
        run_op("inf/-inf", 16'h7F80, 16'hFF80, 16'h7FC0, 1, 4'b1000, 0);
        run_op("-0/2",     16'h8000, 16'h4000, 16'h8000, 1, 4'b0000, 0);
        run_op("2/-inf",   16'h4000, 16'hFF80, 16'h8000, 1, 4'b0000, 0);
        run_op("-inf/2",   16'hFF80, 16'h4000, 16'hFF80, 1, 4'b0000, 0);

        // output back-pressure, then back-to-back issue
        run_op("hold",     16'h4385, 16'h4188, 16'h417A, 12, 4'b0000, 5);
        run_op("b2b",      16'h3F80, 16'h4040, 16'h3EAB, 12, 4'b0000, 0);

        // reset in the middle of DIVIDE
        a        = 16'h3F80;
        b        = 16'h4040;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst:out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst:result", {16'd0, result}, 32'd0);
        chk("midrst:in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (14) @(negedge clk);
        chk("midrst:no_valid", {31'd0, out_valid}, 32'd0);
        run_op("after_rst", 16'h4385, 16'h4188, 16'h417A, 12, 4'b0000, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
